// File: rtl/cnn_quad_job_ctrl_if.sv
// Bus bundle for cnn_quad_job_ctrl.
// Groups configuration load, sequence memory read, job handshake, pixel stream and row-buffer
// write port. The controller uses the slave modport; the driving environment uses master.
interface cnn_quad_job_ctrl_if #(
  parameter int unsigned C_PIXEL_WIDTH = 16,
  parameter int unsigned C_NUM_LANES   = 8,
  parameter int unsigned C_SEQ_DEPTH   = 512,
  parameter int unsigned C_DIM_WIDTH   = 10
);
  localparam int unsigned BeatWidth = C_PIXEL_WIDTH * C_NUM_LANES;
  localparam int unsigned AddrWidth = $clog2(C_SEQ_DEPTH);

  // Job geometry
  logic [C_DIM_WIDTH-1:0] cfg_num_rows;
  logic [C_DIM_WIDTH-1:0] cfg_num_cols;
  // Configuration load
  logic [3:0]             config_valid;
  logic [3:0]             config_accept;
  logic [BeatWidth-1:0]   config_data;
  // Sequence memory read
  logic [AddrWidth-1:0]   seq_rd_addr;
  logic [BeatWidth-1:0]   seq_rd_data;
  logic [AddrWidth:0]     seq_wr_count;
  // Job handshake
  logic                   job_start;
  logic                   job_accept;
  logic                   job_fetch_request;
  logic                   job_fetch_ack;
  logic                   job_fetch_complete;
  logic                   job_complete;
  logic                   job_complete_ack;
  // Pixel stream
  logic                   pixel_valid;
  logic                   pixel_ready;
  logic [BeatWidth-1:0]   pixel_data;
  // Row-buffer write port
  logic                   row_wr_en;
  logic [C_DIM_WIDTH-1:0] row_wr_row;
  logic [C_DIM_WIDTH-1:0] row_wr_col;
  logic [BeatWidth-1:0]   row_wr_data;

  modport master (
    output cfg_num_rows, cfg_num_cols, config_valid, config_data, seq_rd_addr,
           job_start, job_fetch_ack, job_fetch_complete, job_complete_ack,
           pixel_valid, pixel_data,
    input  config_accept, seq_rd_data, seq_wr_count, job_accept, job_fetch_request,
           job_complete, pixel_ready, row_wr_en, row_wr_row, row_wr_col, row_wr_data
  );

  modport slave (
    input  cfg_num_rows, cfg_num_cols, config_valid, config_data, seq_rd_addr,
           job_start, job_fetch_ack, job_fetch_complete, job_complete_ack,
           pixel_valid, pixel_data,
    output config_accept, seq_rd_data, seq_wr_count, job_accept, job_fetch_request,
           job_complete, pixel_ready, row_wr_en, row_wr_row, row_wr_col, row_wr_data
  );
endinterface

// File: rtl/cnn_quad_job_ctrl.sv
// Job controller for one CNN layer-accelerator quad.
// - Loads 128-bit sequencer words into a sequence memory while idle (config_valid/accept).
// - Synchronous 1-cycle sequence memory read port (seq_rd_addr -> seq_rd_data).
// - Runs the job handshake: start/accept, per-row fetch request/ack/complete, complete/ack.
// - Accepts pixel beats row by row and drives a registered row-buffer write port.
// Ports: clk, rst_n (async active-low) and bus_io (slave side of cnn_quad_job_ctrl_if).
module cnn_quad_job_ctrl #(
  parameter int unsigned C_PIXEL_WIDTH = 16,
  parameter int unsigned C_NUM_LANES   = 8,
  parameter int unsigned C_SEQ_DEPTH   = 512,
  parameter int unsigned C_DIM_WIDTH   = 10
) (
  input logic                 clk,
  input logic                 rst_n,
  cnn_quad_job_ctrl_if.slave  bus_io
);
  localparam int unsigned BeatWidth  = C_PIXEL_WIDTH * C_NUM_LANES;
  localparam int unsigned AddrWidth  = $clog2(C_SEQ_DEPTH);
  localparam int unsigned CountWidth = AddrWidth + 1;

  typedef enum logic [2:0] {
    StIdle,
    StAccept,
    StFetchReq,
    StLoad,
    StWaitDone,
    StComplete
  } state_e;

  state_e state_q, state_d;

  // Sequence memory; contents deliberately survive reset.
  logic [BeatWidth-1:0]   mem_q [C_SEQ_DEPTH];
  logic [AddrWidth-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CountWidth-1:0]  wr_count_q, wr_count_d;
  logic [BeatWidth-1:0]   rd_data_q;
  logic                   cfg_fire;

  logic [C_DIM_WIDTH-1:0] num_rows_q, num_rows_d;
  logic [C_DIM_WIDTH-1:0] num_cols_q, num_cols_d;
  logic [C_DIM_WIDTH-1:0] row_q, row_d;
  // One extra bit so col can step past a num_cols of all ones.
  logic [C_DIM_WIDTH:0]   col_q, col_d;

  logic                   pix_ready;
  logic                   pix_fire;
  logic                   last_beat;

  logic                   wr_en_q;
  logic [C_DIM_WIDTH-1:0] wr_row_q;
  logic [C_DIM_WIDTH-1:0] wr_col_q;
  logic [BeatWidth-1:0]   wr_data_q;

  logic                   unused_cfg_valid;
  assign unused_cfg_valid = ^bus_io.config_valid[3:1];

  // ---------------------------------------------------------------------------
  // Configuration load and sequence memory
  // ---------------------------------------------------------------------------
  // Gated by rst_n so the accept output is also low while reset is held.
  assign cfg_fire = rst_n & (state_q == StIdle) & bus_io.config_valid[0];

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    wr_count_d = wr_count_q;
    if (cfg_fire) begin
      wr_ptr_d = wr_ptr_q + 1'b1;  // power-of-two depth wraps naturally
      if (wr_count_q != CountWidth'(C_SEQ_DEPTH)) begin
        wr_count_d = wr_count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      wr_count_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      wr_count_q <= wr_count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (cfg_fire) begin
      mem_q[wr_ptr_q] <= bus_io.config_data;
    end
  end

  // Read-before-write: a same-cycle write to the read address returns the old word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= mem_q[bus_io.seq_rd_addr];
    end
  end

  // ---------------------------------------------------------------------------
  // Job state machine
  // ---------------------------------------------------------------------------
  assign pix_ready = (state_q == StLoad) && (col_q <= {1'b0, num_cols_q});
  assign pix_fire  = pix_ready & bus_io.pixel_valid;
  assign last_beat = pix_fire && (col_q == {1'b0, num_cols_q});

  always_comb begin
    state_d    = state_q;
    num_rows_d = num_rows_q;
    num_cols_d = num_cols_q;
    row_d      = row_q;
    col_d      = col_q;
    unique case (state_q)
      StIdle: begin
        if (bus_io.job_start) begin
          state_d    = StAccept;
          num_rows_d = bus_io.cfg_num_rows;
          num_cols_d = bus_io.cfg_num_cols;
          row_d      = '0;
        end
      end
      StAccept: begin
        state_d = StFetchReq;
      end
      StFetchReq: begin
        if (bus_io.job_fetch_ack) begin
          state_d = StLoad;
          col_d   = '0;
        end
      end
      StLoad: begin
        // job_fetch_complete is intentionally not looked at until the row is full.
        if (pix_fire) begin
          col_d = col_q + 1'b1;
          if (last_beat) begin
            state_d = StWaitDone;
          end
        end
      end
      StWaitDone: begin
        if (bus_io.job_fetch_complete) begin
          if (row_q == num_rows_q) begin
            state_d = StComplete;
          end else begin
            row_d   = row_q + 1'b1;
            state_d = StFetchReq;
          end
        end
      end
      StComplete: begin
        if (bus_io.job_complete_ack) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      num_rows_q <= '0;
      num_cols_q <= '0;
      row_q      <= '0;
      col_q      <= '0;
    end else begin
      state_q    <= state_d;
      num_rows_q <= num_rows_d;
      num_cols_q <= num_cols_d;
      row_q      <= row_d;
      col_q      <= col_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Row-buffer write port: registered copy of each accepted beat
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_q   <= 1'b0;
      wr_row_q  <= '0;
      wr_col_q  <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= pix_fire;
      if (pix_fire) begin
        wr_row_q  <= row_q;
        wr_col_q  <= col_q[C_DIM_WIDTH-1:0];
        wr_data_q <= bus_io.pixel_data;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus_io.config_accept     = {3'b000, cfg_fire};
  assign bus_io.seq_rd_data       = rd_data_q;
  assign bus_io.seq_wr_count      = wr_count_q;
  assign bus_io.job_accept        = (state_q == StAccept);
  assign bus_io.job_fetch_request = (state_q == StFetchReq);
  assign bus_io.job_complete      = (state_q == StComplete);
  assign bus_io.pixel_ready       = pix_ready;
  assign bus_io.row_wr_en         = wr_en_q;
  assign bus_io.row_wr_row        = wr_row_q;
  assign bus_io.row_wr_col        = wr_col_q;
  assign bus_io.row_wr_data       = wr_data_q;

endmodule

// File: tb/tb_cnn_quad_job_ctrl.sv
// Self-checking bench for cnn_quad_job_ctrl. Inputs are driven and outputs sampled around the
// falling clock edge. A reference model tracks the sequence memory as a plain array with a
// modulo write pointer and a saturating count; expected row-buffer writes are the beats the
// bench itself handed over, tagged with the row it is feeding and a running column index.
module tb_cnn_quad_job_ctrl;
  localparam int unsigned Depth = 512;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  cnn_quad_job_ctrl_if bus ();
  cnn_quad_job_ctrl dut (.clk(clk), .rst_n(rst_n), .bus_io(bus));

  int n_pass = 0;
  int n_total = 0;

  // Reference model of the sequence memory
  logic [127:0] m_mem [Depth];
  int m_ptr = 0;
  int m_cnt = 0;

  // Event counters, only written by this monitor
  int n_wr = 0;
  int n_acc = 0;
  int n_freq = 0;
  logic freq_prev = 1'b0;
  always @(negedge clk) begin
    if (bus.row_wr_en) n_wr <= n_wr + 1;
    if (bus.job_accept) n_acc <= n_acc + 1;
    if (bus.job_fetch_request && !freq_prev) n_freq <= n_freq + 1;
    freq_prev <= bus.job_fetch_request;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed running expected done");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_write(input logic [127:0] d);
    m_mem[m_ptr] = d;
    m_ptr = (m_ptr + 1) % Depth;
    if (m_cnt < Depth) m_cnt++;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_cfg_accept"}, 160'(bus.config_accept), 160'(0));
    check({tag, "_job_accept"}, 160'(bus.job_accept), 160'(0));
    check({tag, "_fetch_req"}, 160'(bus.job_fetch_request), 160'(0));
    check({tag, "_complete"}, 160'(bus.job_complete), 160'(0));
    check({tag, "_pixel_ready"}, 160'(bus.pixel_ready), 160'(0));
    check({tag, "_wr_en"}, 160'(bus.row_wr_en), 160'(0));
    check({tag, "_wr_addr"}, 160'({bus.row_wr_row, bus.row_wr_col}), 160'(0));
    check({tag, "_wr_data"}, 160'(bus.row_wr_data), 160'(0));
    check({tag, "_rd_data"}, 160'(bus.seq_rd_data), 160'(0));
    check({tag, "_wr_count"}, 160'(bus.seq_wr_count), 160'(0));
  endtask

  // Every beat offered in IDLE is expected to be accepted and written.
  task automatic cfg_load(input string tag, input int n, input int unsigned salt);
    int n_ok = 0;
    logic [127:0] d;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      d = {$urandom, $urandom, $urandom, 32'(salt + 32'(i))};
      bus.config_valid = 4'b0001;
      bus.config_data = d;
      #1;
      if (bus.config_accept === 4'b0001) n_ok++;
      model_write(d);
    end
    @(negedge clk);
    bus.config_valid = 4'b0000;
    check(tag, 160'(n_ok), 160'(n));
  endtask

  task automatic rd_check(input string tag, input int addr);
    @(negedge clk);
    bus.seq_rd_addr = 9'(addr);
    @(negedge clk);
    check(tag, 160'(bus.seq_rd_data), 160'(m_mem[addr]));
  endtask

  task automatic start_job(input int rows, input int cols);
    @(negedge clk);
    bus.cfg_num_rows = 10'(rows);
    bus.cfg_num_cols = 10'(cols);
    bus.job_start = 1'b1;
    @(negedge clk);
    check("accept_pulse", 160'(bus.job_accept), 160'(1));
    check("no_req_in_accept", 160'(bus.job_fetch_request), 160'(0));
    bus.job_start = 1'b0;
    bus.cfg_num_rows = 10'($urandom);  // must have been latched already
    bus.cfg_num_cols = 10'($urandom);
    bus.config_valid = 4'b0001;
    #1;
    check("cfg_blocked_accept", 160'(bus.config_accept), 160'(0));
    @(negedge clk);
    check("accept_dropped", 160'(bus.job_accept), 160'(0));
    check("req_after_accept", 160'(bus.job_fetch_request), 160'(1));
    check("cfg_blocked_req", 160'(bus.config_accept), 160'(0));
    bus.config_valid = 4'b0000;
  endtask

  // Feed one row. stop_after >= 0 returns once that many beats were handed over.
  task automatic do_row(input int r, input int ncols, input int stop_after, input bit strays);
    bit found = 1'b0;
    bit v;
    int sent = 0;
    int nwr0;
    logic [127:0] d;
    logic [127:0] exp_d[$];
    logic [147:0] got[$];
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.job_fetch_request) begin
        found = 1'b1;
        break;
      end
    end
    check("fetch_req_seen", 160'(found), 160'(1));
    if (!found) return;
    nwr0 = n_wr;
    // Beat offered while not ready must not be written.
    bus.pixel_valid = 1'b1;
    bus.pixel_data = {$urandom, $urandom, $urandom, $urandom};
    #1;
    check("ready_low_in_req", 160'(bus.pixel_ready), 160'(0));
    bus.job_fetch_ack = 1'b1;
    @(negedge clk);
    bus.job_fetch_ack = 1'b0;
    if (strays) begin
      bus.job_fetch_complete = 1'b1;
      bus.job_fetch_ack = 1'b1;
      bus.job_complete_ack = 1'b1;
    end
    for (int k = 0; k < 200 && sent <= ncols; k++) begin
      v = ($urandom_range(0, 3) != 0);
      d = {$urandom, $urandom, $urandom, $urandom};
      bus.pixel_valid = v;
      bus.pixel_data = d;
      #1;
      if (bus.row_wr_en) got.push_back({bus.row_wr_row, bus.row_wr_col, bus.row_wr_data});
      if (v && bus.pixel_ready) begin
        exp_d.push_back(d);
        sent++;
      end
      @(negedge clk);
      bus.job_fetch_complete = 1'b0;
      bus.job_fetch_ack = 1'b0;
      bus.job_complete_ack = 1'b0;
      if (stop_after >= 0 && sent == stop_after) return;
    end
    check("beats_taken", 160'(sent), 160'(ncols + 1));
    bus.pixel_valid = 1'b1;
    bus.pixel_data = {$urandom, $urandom, $urandom, $urandom};
    #1;
    check("ready_low_after_row", 160'(bus.pixel_ready), 160'(0));
    if (bus.row_wr_en) got.push_back({bus.row_wr_row, bus.row_wr_col, bus.row_wr_data});
    @(negedge clk);
    bus.pixel_valid = 1'b0;
    #1;
    if (bus.row_wr_en) got.push_back({bus.row_wr_row, bus.row_wr_col, bus.row_wr_data});
    check("row_write_count", 160'(got.size()), 160'(ncols + 1));
    check("row_write_total", 160'(n_wr - nwr0), 160'(ncols + 1));
    for (int j = 0; j < got.size() && j < exp_d.size(); j++) begin
      check("row_write_entry", 160'(got[j]), 160'({10'(r), 10'(j), exp_d[j]}));
    end
    bus.job_fetch_complete = 1'b1;
    @(negedge clk);
    bus.job_fetch_complete = 1'b0;
  endtask

  task automatic finish_job();
    bit seen = 1'b0;
    int held = 0;
    logic [127:0] d;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.job_complete) begin
        seen = 1'b1;
        break;
      end
    end
    check("complete_seen", 160'(seen), 160'(1));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (bus.job_complete) held++;
    end
    check("complete_held", 160'(held), 160'(5));
    bus.job_complete_ack = 1'b1;
    @(negedge clk);
    bus.job_complete_ack = 1'b0;
    check("complete_cleared", 160'(bus.job_complete), 160'(0));
    d = {$urandom, $urandom, $urandom, $urandom};
    bus.config_valid = 4'b0001;
    bus.config_data = d;
    #1;
    check("cfg_accept_idle", 160'(bus.config_accept), 160'(1));
    model_write(d);
    @(negedge clk);
    bus.config_valid = 4'b0000;
    rd_check("cfg_after_job", (m_ptr + Depth - 1) % Depth);
  endtask

  initial begin
    int acc0;
    int fr0;
    logic [127:0] d;
    logic [127:0] old;
    bus.cfg_num_rows = '0;
    bus.cfg_num_cols = '0;
    bus.config_valid = '0;
    bus.config_data = '0;
    bus.seq_rd_addr = '0;
    bus.job_start = 1'b0;
    bus.job_fetch_ack = 1'b0;
    bus.job_fetch_complete = 1'b0;
    bus.job_complete_ack = 1'b0;
    bus.pixel_valid = 1'b0;
    bus.pixel_data = '0;

    #3 rst_n = 1'b0;
    #4;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Fill the whole memory, then wrap
    cfg_load("cfg_accept_512", 512, 32'h0001_0000);
    check("wr_count_full", 160'(bus.seq_wr_count), 160'(m_cnt));
    rd_check("rd_addr5", 5);
    for (int i = 0; i < 3; i++) rd_check("rd_random", $urandom_range(0, Depth - 1));
    cfg_load("cfg_accept_wrap", 3, 32'h0002_0000);
    check("wr_count_saturated", 160'(bus.seq_wr_count), 160'(m_cnt));
    rd_check("rd_wrapped0", 0);
    rd_check("rd_not_wrapped3", 3);

    // Read and write of the same address in one cycle returns the old word
    @(negedge clk);
    d = {$urandom, $urandom, $urandom, $urandom};
    old = m_mem[m_ptr];
    bus.config_valid = 4'b0001;
    bus.config_data = d;
    bus.seq_rd_addr = 9'(m_ptr);
    @(negedge clk);
    bus.config_valid = 4'b0000;
    check("rd_during_wr_old", 160'(bus.seq_rd_data), 160'(old));
    model_write(d);
    rd_check("rd_after_wr_new", (m_ptr + Depth - 1) % Depth);

    // Full 10x10 job
    acc0 = n_acc;
    fr0 = n_freq;
    start_job(9, 9);
    for (int r = 0; r <= 9; r++) do_row(r, 9, -1, r == 1);
    finish_job();
    check("accept_pulses", 160'(n_acc - acc0), 160'(1));
    check("fetch_requests", 160'(n_freq - fr0), 160'(10));
    rd_check("mem_untouched_by_job", (m_ptr + Depth - 2) % Depth);

    // Abort during row 4, then a fresh job starts from row 0
    start_job(5, 3);
    for (int r = 0; r <= 3; r++) do_row(r, 3, -1, 1'b0);
    do_row(4, 3, 2, 1'b0);
    rst_n = 1'b0;
    #1;
    check_zero("abort");
    bus.pixel_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_ptr = 0;
    m_cnt = 0;
    rd_check("mem_kept_after_reset", 7);
    acc0 = n_acc;
    fr0 = n_freq;
    start_job(1, 2);
    for (int r = 0; r <= 1; r++) do_row(r, 2, -1, r == 0);
    finish_job();
    check("accept_pulses2", 160'(n_acc - acc0), 160'(1));
    check("fetch_requests2", 160'(n_freq - fr0), 160'(2));
    check("wr_count_after_reset", 160'(bus.seq_wr_count), 160'(m_cnt));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/cnn_quad_job_ctrl.md
Name: cnn_quad_job_ctrl

Overview:
- Single-clock control block for one CNN layer-accelerator quad.
- Loads sequencer configuration words into an internal sequence memory.
- Runs the job handshake: start/accept, per-row fetch request/ack/complete, and completion/ack.
- Accepts input pixel vectors row by row and drives a row-buffer write port toward the AWE row buffers.

Parameters:
- C_PIXEL_WIDTH, 16, width of one pixel/sequence entry lane.
- C_NUM_LANES, 8, pixels (or sequence entries) per 128-bit beat; C_PIXEL_WIDTH*C_NUM_LANES = 128.
- C_SEQ_DEPTH, 512, sequence memory depth in 128-bit words (power of two).
- C_DIM_WIDTH, 10, width of the row/column configuration counts.

Ports:
- clk, in, 1, sole clock.
- rst_n, in, 1, asynchronous active-low reset.
- cfg_num_rows, in, C_DIM_WIDTH, input rows minus 1; sampled at job accept.
- cfg_num_cols, in, C_DIM_WIDTH, input columns minus 1; sampled at job accept.
- config_valid, in, 4, configuration valid; only bit 0 is used.
- config_accept, out, 4, configuration accept; bits 3:1 are always 0.
- config_data, in, 128, eight 16-bit sequence entries; entry n occupies bits [16n+15:16n].
- seq_rd_addr, in, log2(C_SEQ_DEPTH), sequence memory read address.
- seq_rd_data, out, 128, sequence memory read data.
- seq_wr_count, out, log2(C_SEQ_DEPTH)+1, number of configuration words written.
- job_start, in, 1, request to start a job.
- job_accept, out, 1, one-cycle pulse when the job is accepted.
- job_fetch_request, out, 1, request for the next input row.
- job_fetch_ack, in, 1, fetch request acknowledged.
- job_fetch_complete, in, 1, current row delivery finished.
- job_complete, out, 1, job finished.
- job_complete_ack, in, 1, completion acknowledged.
- pixel_valid, in, 1, pixel beat valid.
- pixel_ready, out, 1, pixel beat ready.
- pixel_data, in, 128, eight lanes, one per input depth channel.
- row_wr_en, out, 1, row-buffer write strobe.
- row_wr_row, out, C_DIM_WIDTH, row index of the write.
- row_wr_col, out, C_DIM_WIDTH, column index of the write.
- row_wr_data, out, 128, write data (registered copy of pixel_data).

Behaviour:
- Reset:
  - All outputs 0, state IDLE, write pointer 0, row and column counters 0.
  - Sequence memory contents are not cleared.
  - Asserting reset mid-job aborts the job immediately.
- Sequence entry format (stored only; this block does not interpret it): [9:0] address, [10] parity, [11] row-start, [12] row-end, [15:13] reserved.
- Configuration load:
  - In IDLE, config_accept[0] = config_valid[0] (combinational).
  - Outside IDLE, config_accept = 0.
  - Each accepted beat writes config_data to mem[wr_ptr], then wr_ptr increments.
  - Pointer wraps from C_SEQ_DEPTH-1 to 0.
  - seq_wr_count saturates at C_SEQ_DEPTH.
- Sequence read: synchronous, 1-cycle latency; a read of an address being written in the same cycle returns the old data.
- State machine: IDLE -> ACCEPT -> FETCH_REQ -> LOAD -> WAIT_DONE -> (FETCH_REQ | COMPLETE) -> IDLE.
  - IDLE:
    - job_start=1 -> ACCEPT.
    - Latch cfg_num_rows and cfg_num_cols; clear the row counter.
  - ACCEPT:
    - job_accept=1 for exactly one cycle -> FETCH_REQ.
    - job_start must be held until accept; a job_start still high on the return to IDLE starts a new job.
  - FETCH_REQ:
    - job_fetch_request=1.
    - On job_fetch_ack -> LOAD, clear the column counter.
  - LOAD:
    - pixel_ready=1 while col <= num_cols.
    - Each pixel_valid & pixel_ready beat registers row_wr_en=1 with the current row, col and data (1-cycle latency); col then increments.
    - After num_cols+1 beats, pixel_ready deasserts -> WAIT_DONE.
  - WAIT_DONE:
    - On job_fetch_complete, if row == num_rows -> COMPLETE; else row+1 -> FETCH_REQ.
    - job_fetch_complete received while in LOAD is ignored; the source must pulse it after the row is full.
  - COMPLETE:
    - job_complete=1 until job_complete_ack -> IDLE.
    - After the ack, job_complete is 0 on the next cycle.
- Stray handshakes:
  - job_fetch_ack outside FETCH_REQ is ignored.
  - job_complete_ack outside COMPLETE is ignored.
  - pixel_valid without pixel_ready produces no write.

Test Plan:
- Reset, then config_valid[0]=1 for 512 beats of distinct data -> config_accept[0] high each cycle; seq_wr_count=512; seq_rd_addr=5 returns beat 5 one cycle later.
- Writing beyond 512 beats -> pointer wraps; beat 512 overwrites address 0; seq_wr_count stays at 512.
- cfg_num_rows=9, cfg_num_cols=9, job_start=1 -> job_accept pulses once; job_fetch_request rises the next cycle; config_accept is 0 while the job runs.
- Per row: ack, stream 10 beats with occasional pixel_valid gaps, then pulse job_fetch_complete -> exactly 10 writes with cols 0..9 and the correct row; pixel_ready low after beat 10; 10 fetch requests in total, then job_complete.
- Hold job_complete_ack low for 5 cycles -> job_complete stays high; after the ack, state is IDLE and config is accepted again.
- Assert rst_n low during row 4 LOAD -> all outputs 0 immediately; a new job starts from row 0.
